// File: rtl/alu_shift_sequencer_pkg.sv
// Shared ALU types: register word, ALU op encodings and the shift
// sequencer state enum, plus a helper that classifies shift ops.
package alu_shift_sequencer_pkg;

  // Register-file word
  typedef logic [31:0] t_reg;

  // ALU operation encodings shared by the ALU and its controllers
  typedef enum logic [3:0] {
    OP_ADD         = 4'd0,
    OP_SUB         = 4'd1,
    OP_AND         = 4'd2,
    OP_OR          = 4'd3,
    OP_XOR         = 4'd4,
    OP_LOGIC_LEFT  = 4'd5,
    OP_LOGIC_RIGHT = 4'd6,
    OP_ARITH_LEFT  = 4'd7,
    OP_ARITH_RIGHT = 4'd8
  } t_alu_op;

  // Multi-cycle shift sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } t_shift_seq_state;

  // True for the four single-bit shift operations the sequencer can iterate
  function automatic logic is_shift_op(input t_alu_op op);
    logic r;
    case (op)
      OP_LOGIC_LEFT,
      OP_LOGIC_RIGHT,
      OP_ARITH_LEFT,
      OP_ARITH_RIGHT: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Shift ops move reg2 by exactly one bit; carry reports
// the bit shifted out and over flags a sign change on arithmetic left.
module alu
  import alu_shift_sequencer_pkg::*;
(
  input  t_alu_op     op,
  input  t_reg        reg2,
  input  t_reg        reg3,
  input  logic        carry_in,
  output t_reg        result,
  output logic        carry,
  output logic        zero,
  output logic        neg,
  output logic        over
);

  logic [32:0] sum;

  // Operation select and carry/overflow generation
  always_comb begin
    sum    = 33'd0;
    result = 32'd0;
    carry  = 1'b0;
    over   = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, reg2} + {1'b0, reg3} + {32'd0, carry_in};
        result = sum[31:0];
        carry  = sum[32];
        over   = (reg2[31] == reg3[31]) && (sum[31] != reg2[31]);
      end
      OP_SUB: begin
        sum    = {1'b0, reg2} + {1'b0, ~reg3} + 33'd1;
        result = sum[31:0];
        carry  = sum[32];
        over   = (reg2[31] != reg3[31]) && (sum[31] != reg2[31]);
      end
      OP_AND: result = reg2 & reg3;
      OP_OR:  result = reg2 | reg3;
      OP_XOR: result = reg2 ^ reg3;
      OP_LOGIC_LEFT: begin
        result = {reg2[30:0], 1'b0};
        carry  = reg2[31];
      end
      OP_LOGIC_RIGHT: begin
        result = {1'b0, reg2[31:1]};
        carry  = reg2[0];
      end
      OP_ARITH_LEFT: begin
        result = {reg2[30:0], 1'b0};
        carry  = reg2[31];
        over   = reg2[31] ^ reg2[30];
      end
      OP_ARITH_RIGHT: begin
        result = {reg2[31], reg2[31:1]};
        carry  = reg2[0];
      end
      default: begin
        result = 32'd0;
        carry  = 1'b0;
        over   = 1'b0;
      end
    endcase
  end

  assign zero = (result == 32'd0);
  assign neg  = result[31];

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter: iterates the ALU's single-bit shift ops N times,
// feeding each ALU result back as the next operand, and reports the final
// value and flags with a one-cycle done pulse.
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  t_alu_op     shift_op,
  input  t_reg        operand,
  input  logic [4:0]  count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output t_reg        result,
  output logic        carry_out,
  output logic        zero_out,
  output logic        neg_out,
  output logic        over_out,
  output t_alu_op     alu_op,
  output t_reg        alu_reg2,
  output t_reg        alu_reg3,
  output logic        alu_carry_in,
  input  t_reg        alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_over
);

  t_shift_seq_state state, state_next;
  t_reg             acc, acc_next;
  logic [4:0]       remaining, remaining_next;
  t_alu_op          op_q, op_q_next;
  logic             over_sticky, over_sticky_next;

  logic             busy_next;
  logic             done_next;
  logic             error_next;
  t_reg             result_next;
  logic             carry_next;
  logic             zero_next;
  logic             neg_next;
  logic             over_next;

  // Next-state and next-output logic; results/flags hold unless a completion occurs
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    remaining_next   = remaining;
    op_q_next        = op_q;
    over_sticky_next = over_sticky;
    done_next        = 1'b0;
    error_next       = 1'b0;
    result_next      = result;
    carry_next       = carry_out;
    zero_next        = zero_out;
    neg_next         = neg_out;
    over_next        = over_out;

    case (state)
      IDLE: begin
        if (start) begin
          if (!is_shift_op(shift_op)) begin
            // Not a shift: reject immediately, pass the operand through
            done_next   = 1'b1;
            error_next  = 1'b1;
            result_next = operand;
            carry_next  = 1'b0;
            zero_next   = 1'b0;
            neg_next    = 1'b0;
            over_next   = 1'b0;
          end else if (count == 5'd0) begin
            // Zero-length shift completes without touching the ALU
            done_next   = 1'b1;
            error_next  = 1'b0;
            result_next = operand;
            carry_next  = 1'b0;
            zero_next   = (operand == 32'd0);
            neg_next    = operand[31];
            over_next   = 1'b0;
          end else begin
            acc_next         = operand;
            op_q_next        = shift_op;
            remaining_next   = count;
            over_sticky_next = 1'b0;
            state_next       = SHIFT;
          end
        end else begin
          state_next = IDLE;
        end
      end

      SHIFT: begin
        acc_next         = alu_result;
        over_sticky_next = over_sticky | alu_over;
        if (remaining <= 5'd1) begin
          // Last step: capture the ALU result and flags as the final answer
          remaining_next = 5'd0;
          result_next    = alu_result;
          carry_next     = alu_carry;
          zero_next      = alu_zero;
          neg_next       = alu_neg;
          over_next      = over_sticky | alu_over;
          done_next      = 1'b1;
          error_next     = 1'b0;
          state_next     = IDLE;
        end else begin
          remaining_next = remaining - 5'd1;
          state_next     = SHIFT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == SHIFT);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= 32'd0;
      remaining   <= 5'd0;
      op_q        <= OP_LOGIC_LEFT;
      over_sticky <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      result      <= 32'd0;
      carry_out   <= 1'b0;
      zero_out    <= 1'b0;
      neg_out     <= 1'b0;
      over_out    <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      remaining   <= remaining_next;
      op_q        <= op_q_next;
      over_sticky <= over_sticky_next;
      busy        <= busy_next;
      done        <= done_next;
      error       <= error_next;
      result      <= result_next;
      carry_out   <= carry_next;
      zero_out    <= zero_next;
      neg_out     <= neg_next;
      over_out    <= over_next;
    end
  end

  // The sequencer owns the ALU inputs; the op and operand come straight from registers
  assign alu_op       = op_q;
  assign alu_reg2     = acc;
  assign alu_reg3     = 32'd0;
  assign alu_carry_in = 1'b0;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench: sequencer wired to the ALU, hand-computed expectations.
module tb_alu_shift_sequencer;
  import alu_shift_sequencer_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  t_alu_op    shift_op;
  t_reg       operand;
  logic [4:0] count;
  logic       busy, done, error;
  t_reg       result;
  logic       carry_out, zero_out, neg_out, over_out;
  t_alu_op    alu_op;
  t_reg       alu_reg2, alu_reg3;
  logic       alu_carry_in;
  t_reg       alu_result;
  logic       alu_carry, alu_zero, alu_neg, alu_over;

  int total = 0;
  int bad   = 0;

  alu_shift_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .shift_op(shift_op),
    .operand(operand), .count(count), .busy(busy), .done(done), .error(error),
    .result(result), .carry_out(carry_out), .zero_out(zero_out),
    .neg_out(neg_out), .over_out(over_out), .alu_op(alu_op),
    .alu_reg2(alu_reg2), .alu_reg3(alu_reg3), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_over(alu_over)
  );

  alu u_alu (
    .op(alu_op), .reg2(alu_reg2), .reg3(alu_reg3), .carry_in(alu_carry_in),
    .result(alu_result), .carry(alu_carry), .zero(alu_zero),
    .neg(alu_neg), .over(alu_over)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done; counts cycles with busy high on the way
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clock);
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Drive a request now (at a negedge), then wait for completion
  task automatic run_shift(input t_alu_op op, input t_reg val, input logic [4:0] cnt,
                           output int edges, output int busy_cnt);
    int cyc;
    shift_op = op;
    operand  = val;
    count    = cnt;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, busy_cnt);
    edges = cyc + 1;
  endtask

  task automatic check_flags(input string tag, input logic c, input logic z,
                             input logic n, input logic o);
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, c});
    check({tag, "_zero"},  {31'd0, zero_out},  {31'd0, z});
    check({tag, "_neg"},   {31'd0, neg_out},   {31'd0, n});
    check({tag, "_over"},  {31'd0, over_out},  {31'd0, o});
  endtask

  initial begin
    int edges, bcnt, cyc, dcnt;
    reset    = 1'b0;
    start    = 1'b0;
    shift_op = OP_LOGIC_LEFT;
    operand  = 32'd0;
    count    = 5'd0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_result", result, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_alu_op", {28'd0, alu_op}, {28'd0, OP_LOGIC_LEFT});
    check("rst_reg2", alu_reg2, 32'd0);
    check("rst_reg3", alu_reg3, 32'd0);
    check("rst_cin", {31'd0, alu_carry_in}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Logical left 1 by 4
    run_shift(OP_LOGIC_LEFT, 32'h0000_0001, 5'd4, edges, bcnt);
    check("ll4_result", result, 32'h0000_0010);
    check("ll4_error", {31'd0, error}, 32'd0);
    check("ll4_busy_cycles", bcnt, 32'd4);
    check("ll4_latency", edges, 32'd5);
    check("ll4_busy_at_done", {31'd0, busy}, 32'd0);
    check_flags("ll4", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("ll4_done_clear", {31'd0, done}, 32'd0);
    check("ll4_result_hold", result, 32'h0000_0010);

    // Arithmetic right 0x8000_0000 by 31
    run_shift(OP_ARITH_RIGHT, 32'h8000_0000, 5'd31, edges, bcnt);
    check("ar31_result", result, 32'hFFFF_FFFF);
    check("ar31_latency", edges, 32'd32);
    check_flags("ar31", 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start asserted in the done cycle. Logical right 3 by 2
    run_shift(OP_LOGIC_RIGHT, 32'h0000_0003, 5'd2, edges, bcnt);
    check("lr2_result", result, 32'h0000_0000);
    check("lr2_latency", edges, 32'd3);
    check_flags("lr2", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);

    // Arithmetic left 0x4000_0000 by 2: overflow sticky from step 1
    run_shift(OP_ARITH_LEFT, 32'h4000_0000, 5'd2, edges, bcnt);
    check("al2_result", result, 32'h0000_0000);
    check_flags("al2", 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clock);

    // Count 0 completes after a single edge without busy
    run_shift(OP_LOGIC_LEFT, 32'hDEAD_BEEF, 5'd0, edges, bcnt);
    check("c0_result", result, 32'hDEAD_BEEF);
    check("c0_latency", edges, 32'd1);
    check("c0_busy_cycles", bcnt, 32'd0);
    check("c0_error", {31'd0, error}, 32'd0);
    check_flags("c0", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);

    // Non-shift op is rejected with error
    run_shift(OP_ADD, 32'h1234_5678, 5'd3, edges, bcnt);
    check("add_error", {31'd0, error}, 32'd1);
    check("add_result", result, 32'h1234_5678);
    check("add_latency", edges, 32'd1);
    check("add_busy_cycles", bcnt, 32'd0);
    check_flags("add", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("add_error_clear", {31'd0, error}, 32'd0);

    // Start re-pulsed mid-shift with different inputs is ignored
    shift_op = OP_LOGIC_LEFT;
    operand  = 32'h0000_0001;
    count    = 5'd10;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    shift_op = OP_LOGIC_RIGHT;
    operand  = 32'h0000_FFFF;
    count    = 5'd2;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("repulse_result", result, 32'h0000_0400);
    check("repulse_error", {31'd0, error}, 32'd0);
    check("repulse_latency", cyc + 5, 32'd11);
    @(negedge clock);

    // Reset mid-operation aborts with no done
    shift_op = OP_LOGIC_LEFT;
    operand  = 32'h0000_0001;
    count    = 5'd10;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_reg2", alu_reg2, 32'd0);
    check("mid_rst_alu_op", {28'd0, alu_op}, {28'd0, OP_LOGIC_LEFT});
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", dcnt, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Subsequent count-1 shift completes normally
    run_shift(OP_LOGIC_LEFT, 32'h8000_0001, 5'd1, edges, bcnt);
    check("ll1_result", result, 32'h0000_0002);
    check("ll1_latency", edges, 32'd2);
    check("ll1_busy_cycles", bcnt, 32'd1);
    check_flags("ll1", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle shift controller placed between the decode/execute control and the ALU. It performs an N-bit (0–31) shift of a 32-bit operand by repeatedly issuing the ALU's single-bit shift operations, feeding each result back as the next operand. It presents a start/busy/done handshake to the control path, plus the final result and flags. While busy, it owns the ALU's operand and op inputs.

## Interface
Parameters:
- None. Width is fixed at 32 by `t_reg`; the count is 5 bits.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a shift; sampled only in IDLE.
- `shift_op`  in  `t_alu_op`  one of OP_LOGIC_LEFT, OP_LOGIC_RIGHT, OP_ARITH_LEFT, OP_ARITH_RIGHT.
- `operand`  in  `t_reg`  value to shift.
- `count`  in  5  number of single-bit steps, 0–31.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `done`; set when `shift_op` is not a shift.
- `result`  out  `t_reg`  final value; holds until the next completion.
- `carry_out`, `zero_out`, `neg_out`, `over_out`  out  1 each  final flags.
- `alu_op`  out  `t_alu_op`  to the ALU op input.
- `alu_reg2`  out  `t_reg`  to ALU reg2; equals the accumulator.
- `alu_reg3`  out  `t_reg`  constant 0.
- `alu_carry_in`  out  1  constant 0.
- `alu_result`  in  `t_reg`  ALU result.
- `alu_carry`, `alu_zero`, `alu_neg`, `alu_over`  in  1 each  ALU flags.

## Operation
States:
- **IDLE** and **SHIFT** only.
- Registered state: `acc`, `remaining` (5 b), `op_q`, `over_sticky`, plus output registers.

IDLE, when `start`=1 is sampled:
- **Illegal `shift_op`**: go to IDLE. `done`=1, `error`=1, `result`=`operand`, all flags 0.
- **`count`=0**: go to IDLE. `done`=1, `error`=0, `result`=`operand`, `carry_out`=0, `over_out`=0, `zero_out`=(`operand`==0), `neg_out`=`operand[31]`.
- **Otherwise**: `acc`←`operand`, `op_q`←`shift_op`, `remaining`←`count`, `over_sticky`←0, go to SHIFT.

SHIFT, every edge:
- `acc`←`alu_result`.
- `remaining`←`remaining`−1.
- `over_sticky`←`over_sticky` | `alu_over`.
- If `remaining`=1 at this edge, also: `result`←`alu_result`, `carry_out`←`alu_carry` (bit shifted out on the last step), `zero_out`←`alu_zero`, `neg_out`←`alu_neg`, `over_out`←`over_sticky` | `alu_over`. Then set `done`=1, `error`=0, and go to IDLE.

Outputs and bus ownership:
- `alu_op`=`op_q` and `alu_reg2`=`acc` at all times. These are combinational from registers, with no ALU-side latency assumed.
- `start` while in SHIFT is ignored; it is not queued.
- `done` and `error` are registered and cleared on the edge after they are set.

Reset (`reset`=0 on an edge), including mid-operation:
- Go to IDLE.
- `acc`=0, `remaining`=0, `op_q`=OP_LOGIC_LEFT.
- `busy`, `done`, `error` = 0.
- `result`=0 and all flags 0.
- No `done` is produced for an aborted shift.

## Timing
- The edge sampling `start` is E0.
- Count N≥1: steps occur at E1..EN. `busy` is high from after E0 until after EN. `done` is high in the cycle after EN. Total latency is N+1 edges.
- `count`=0 or illegal op: `done` is high in the cycle after E0; `busy` never asserts.
- Back-to-back operation: `start` may be asserted in the same cycle that `done` is high. It is sampled as a new request at that edge, since the block is in IDLE.
- `result` and flags are stable from the `done` cycle until the next completion or reset.

## Structure
- The op encodings (`t_alu_op`) stay in the ALU's shared header.
- `t_reg` stays in the register header.
- Add a `t_shift_seq_state` enum (IDLE, SHIFT) to the ALU header.
- No sub-module is needed. The ALU is instantiated alongside this block by the parent, not inside it.
- The bench instantiates both the sequencer and the ALU wired together.

## Test plan
- OP_LOGIC_LEFT, 0x0000_0001, count 4 -> `result` 0x0000_0010, `carry_out` 0, `zero_out` 0; `done` in the cycle after E4; `busy` high for 4 cycles.
- OP_ARITH_RIGHT, 0x8000_0000, count 31 -> `result` 0xFFFF_FFFF, `neg_out` 1, `carry_out` 0, `over_out` 0.
- OP_LOGIC_RIGHT, 0x0000_0003, count 2 -> `result` 0, `zero_out` 1, `carry_out` 1.
- OP_ARITH_LEFT, 0x4000_0000, count 2 -> `result` 0, `carry_out` 1, `over_out` 1 (sticky from step 1).
- Edge cases:
  - count 0 with 0xDEAD_BEEF -> `done`+0xDEAD_BEEF after one edge, `neg_out` 1, `busy` never high.
  - OP_ADD -> `done`+`error`, `result`=`operand`.
- Control cases:
  - OP_LOGIC_LEFT count 10, with `start` re-pulsed at step 3 (other inputs changed) -> ignored; the original result is produced.
  - Restart the same op, then assert `reset` low at step 5 -> IDLE next cycle, all outputs 0, no `done`.
  - A subsequent start with count 1 completes normally.
